stereo_cqueue: RTL and testbench

Stereo circular sample queue that sits directly upstream of the equalizer FIR band filters. It captures one left/right 16-bit sample pair per `wrt_smpl` strobe into a circular buffer. Once it holds `NUM_TAPS` samples, each new write triggers a burst that streams the most recent `NUM_TAPS` pairs, oldest first, one per clock, with `sequencing` high. Every FIR band consumes this burst in parallel, multiplying each sample by its coefficient ROM entry.

---
 rtl/stereo_cqueue.sv | 148 ++++++++++++++
 tb/tb_stereo_cqueue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/stereo_cqueue.sv
// stereo_cqueue
// Stereo circular sample queue feeding the equalizer FIR band filters.
// Each wrt_smpl strobe captures one left/right sample pair. Once NUM_TAPS
// samples are held, every new write triggers a burst that streams the most
// recent NUM_TAPS pairs, oldest first, one per clock, with sequencing high.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   wrt_smpl   in   single-cycle write strobe
//   lft_in     in   [15:0] left sample (signed)
//   rght_in    in   [15:0] right sample (signed)
//   sequencing out  high while a burst is presented
//   lft_out    out  [15:0] left sample of current burst position (registered)
//   rght_out   out  [15:0] right sample of current burst position (registered)
//   full       out  high once NUM_TAPS samples have been stored since reset
module stereo_cqueue #(
  parameter int DEPTH    = 1024,
  parameter int NUM_TAPS = 1021
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_in,
  input  logic [15:0] rght_in,
  output logic        sequencing,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_TAPS + 1);
  localparam logic [AW-1:0] TAPS_A  = AW'(NUM_TAPS);
  localparam logic [CW-1:0] TAPS_C  = CW'(NUM_TAPS);
  localparam logic [CW-1:0] TAPS_M1 = CW'(NUM_TAPS - 1);

  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  state_t state, next_state;

  logic [15:0]   lft_mem  [DEPTH];
  logic [15:0]   rght_mem [DEPTH];
  logic [AW-1:0] new_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_start;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rd_cnt;
  logic          pending;
  logic          req;
  logic          last_read;
  logic          load;
  logic          rd_en;

  // A write that leaves cnt at NUM_TAPS completes a window.
  assign req       = wrt_smpl && (cnt >= TAPS_M1);
  assign last_read = (rd_cnt == TAPS_M1);
  assign full      = (cnt == TAPS_C);

  // Oldest slot of the window ending at the newest sample, counting a
  // sample being written on this same edge.
  assign rd_start = new_ptr + {{(AW-1){1'b0}}, wrt_smpl} - TAPS_A;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = READ;
      READ:    if (last_read) next_state = GAP;
      GAP:     next_state = (pending || req) ? READ : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM control outputs: load starts a burst window, rd_en issues one read.
  always_comb begin
    load  = 1'b0;
    rd_en = 1'b0;
    case (state)
      IDLE:    load  = req;
      READ:    rd_en = 1'b1;
      GAP:     load  = pending || req;
      default: ;
    endcase
  end

  // Sample storage has no reset; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (wrt_smpl) begin
      lft_mem[new_ptr]  <= lft_in;
      rght_mem[new_ptr] <= rght_in;
    end
  end

  // Write pointer, fill count and follow-on burst request.
  // Writes during READ collapse into a single pending flag; a write landing
  // on the GAP edge is folded directly into the burst being loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      new_ptr <= '0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (wrt_smpl) begin
        new_ptr <= new_ptr + 1'b1;
        if (cnt != TAPS_C) cnt <= cnt + 1'b1;
      end
      if (load)                           pending <= 1'b0;
      else if (wrt_smpl && state == READ) pending <= 1'b1;
    end
  end

  // Read pointer and per-burst read counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      rd_cnt <= '0;
    end else if (load) begin
      rd_ptr <= rd_start;
      rd_cnt <= '0;
    end else if (rd_en) begin
      rd_ptr <= rd_ptr + 1'b1;
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Registered read port; outputs hold their last value between bursts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sequencing <= 1'b0;
      lft_out    <= '0;
      rght_out   <= '0;
    end else begin
      sequencing <= rd_en;
      if (rd_en) begin
        lft_out  <= lft_mem[rd_ptr];
        rght_out <= rght_mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_stereo_cqueue.sv
// Testbench for stereo_cqueue with DEPTH=8, NUM_TAPS=5.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_stereo_cqueue;

  localparam int DEPTH    = 8;
  localparam int NUM_TAPS = 5;

  logic        clk;
  logic        rst_n;
  logic        wrt_smpl;
  logic [15:0] lft_in;
  logic [15:0] rght_in;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;
  logic        full;

  int num_checks;
  int num_errors;

  stereo_cqueue #(.DEPTH(DEPTH), .NUM_TAPS(NUM_TAPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .lft_in     (lft_in),
    .rght_in    (rght_in),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [15:0] neg16(input int v);
    logic [15:0] r;
    r = 16'(0 - v);
    return r;
  endfunction

  // Present one sample (lft=v, rght=-v) for exactly one rising edge.
  // Returns at the falling edge just after that write edge.
  task automatic applyStimulus(input int v);
    @(negedge clk);
    wrt_smpl = 1'b1;
    lft_in   = 16'(v);
    rght_in  = neg16(v);
    @(negedge clk);
    wrt_smpl = 1'b0;
  endtask

  // sequencing must stay low for n cycles.
  task automatic idleCheck(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput(tag, 32'(sequencing), 32'd0);
    end
  endtask

  // Expect a burst first..first+NUM_TAPS-1 starting on the next cycle,
  // followed by one low cycle. Optionally injects up to two writes at
  // burst positions k1/k2 (value v1/v2); -1 disables.
  task automatic checkBurst(input string tag, input int first,
                            input int k1, input int v1,
                            input int k2, input int v2);
    for (int k = 0; k < NUM_TAPS; k++) begin
      @(negedge clk);
      checkOutput({tag, "_seq"},  32'(sequencing), 32'd1);
      checkOutput({tag, "_lft"},  32'(lft_out),    32'(16'(first + k)));
      checkOutput({tag, "_rght"}, 32'(rght_out),   32'(neg16(first + k)));
      if (k == k1) begin
        wrt_smpl = 1'b1; lft_in = 16'(v1); rght_in = neg16(v1);
      end else if (k == k2) begin
        wrt_smpl = 1'b1; lft_in = 16'(v2); rght_in = neg16(v2);
      end else begin
        wrt_smpl = 1'b0;
      end
    end
    @(negedge clk);
    wrt_smpl = 1'b0;
    checkOutput({tag, "_gap"}, 32'(sequencing), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    wrt_smpl = 1'b0;
    @(negedge clk);
    checkOutput("rst_seq",  32'(sequencing), 32'd0);
    checkOutput("rst_full", 32'(full),       32'd0);
    checkOutput("rst_lft",  32'(lft_out),    32'd0);
    checkOutput("rst_rght", 32'(rght_out),   32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    num_checks = 0;
    num_errors = 0;
    rst_n    = 1'b0;
    wrt_smpl = 1'b0;
    lft_in   = '0;
    rght_in  = '0;

    // Fill: writes 1..4 produce nothing, write 5 completes the window.
    doReset();
    for (int v = 1; v <= 4; v++) begin
      applyStimulus(v);
      checkOutput("fill_full_lo", 32'(full), 32'd0);
      idleCheck(9, "fill_noseq");
    end
    applyStimulus(5);
    checkOutput("fill_full_hi", 32'(full), 32'd1);
    checkOutput("fill_seq_e0", 32'(sequencing), 32'd0);
    checkBurst("fill", 1, -1, 0, -1, 0);
    idleCheck(3, "fill_after");

    // Slide and wrap: each write yields a fresh window.
    for (int v = 6; v <= 11; v++) begin
      applyStimulus(v);
      checkBurst("slide", v - NUM_TAPS + 1, -1, 0, -1, 0);
    end

    // Write 12 gives burst 8..12 across slot 7->0; write 13 lands in its
    // second cycle and yields a follow-on burst 9..13 after one gap cycle.
    applyStimulus(12);
    checkBurst("wrap", 8, 1, 13, -1, 0);
    // Two writes inside one burst collapse into a single follow-on burst.
    checkBurst("pend1", 9, 1, 14, 3, 15);
    checkBurst("pend2", 11, -1, 0, -1, 0);
    idleCheck(4, "pend_noextra");

    // Reset mid-burst on the third burst cycle.
    applyStimulus(16);
    @(negedge clk);
    checkOutput("mid_lft0", 32'(lft_out), 32'd12);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_lft2", 32'(lft_out), 32'd14);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_seq",  32'(sequencing), 32'd0);
    checkOutput("mid_rst_lft",  32'(lft_out),    32'd0);
    checkOutput("mid_rst_rght", 32'(rght_out),   32'd0);
    checkOutput("mid_rst_full", 32'(full),       32'd0);
    rst_n = 1'b1;
    for (int v = 21; v <= 24; v++) begin
      applyStimulus(v);
      idleCheck(3, "refill_noseq");
    end
    checkOutput("refill_full_lo", 32'(full), 32'd0);
    applyStimulus(25);
    checkOutput("refill_full_hi", 32'(full), 32'd1);
    checkBurst("refill", 21, -1, 0, -1, 0);

    // Back-to-back strobes from reset.
    doReset();
    for (int v = 1; v <= 5; v++) begin
      @(negedge clk);
      checkOutput("b2b_noseq", 32'(sequencing), 32'd0);
      wrt_smpl = 1'b1;
      lft_in   = 16'(v);
      rght_in  = neg16(v);
    end
    @(negedge clk);
    wrt_smpl = 1'b0;
    checkOutput("b2b_seq_e0", 32'(sequencing), 32'd0);
    checkOutput("b2b_full",   32'(full),       32'd1);
    checkBurst("b2b", 1, -1, 0, -1, 0);
    idleCheck(3, "b2b_after");

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
